// File: rtl/sa_act_skew.sv
// Activation skew feeder for the systolic array: delays row r of each accepted
// vector by r extra cycles and drives the array mode for the pass plus its drain.
module sa_act_skew #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int MUL_DATAWIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [ROWS*MUL_DATAWIDTH-1:0] i_act,
    input  logic                          i_last,
    output logic [ROWS*MUL_DATAWIDTH-1:0] o_act,
    output logic [ROWS-1:0]               o_row_valid,
    output logic                          o_mode,
    output logic                          o_busy,
    output logic                          o_done
);

    // Drain spans the last row's skew plus propagation across every column.
    localparam int DRAIN_LEN = ROWS + COLS - 1;
    localparam int CNT_W     = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] drain_cnt;
    logic             accept;
    logic             drain_end;

    assign accept    = i_valid && o_ready;
    assign drain_end = (state == DRAIN) && (drain_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the combinational processes use blocking ones.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start)          state_next = STREAM;
            STREAM:  if (accept && i_last) state_next = DRAIN;
            DRAIN:   if (drain_end)        state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == STREAM);
        o_busy  = (state != IDLE);
        o_mode  = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            o_done    <= 1'b0;
        end else begin
            drain_cnt <= (state == DRAIN && !drain_end) ? drain_cnt + CNT_W'(1) : '0;
            o_done    <= drain_end;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [MUL_DATAWIDTH-1:0] data_q [0:r];
        logic                     tag_q  [0:r];

        // NOTE: the whole chain is reset, not only the tags, so o_act reads 0
        // after reset instead of stale elements from an aborted pass.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= r; s++) begin
                    data_q[s] <= '0;
                    tag_q[s]  <= 1'b0;
                end
            end else begin
                data_q[0] <= accept ? i_act[r*MUL_DATAWIDTH +: MUL_DATAWIDTH] : '0;
                tag_q[0]  <= accept;
                for (int s = 1; s <= r; s++) begin
                    data_q[s] <= data_q[s-1];
                    tag_q[s]  <= tag_q[s-1];
                end
            end
        end

        assign o_act[r*MUL_DATAWIDTH +: MUL_DATAWIDTH] = data_q[r];
        assign o_row_valid[r]                          = tag_q[r];
    end

endmodule

// File: tb/tb_sa_act_skew.sv
// Self-checking bench for sa_act_skew: directed scenarios plus random traffic,
// all compared against a timeline model of accepted vectors and pass windows.
module tb_sa_act_skew;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int W    = 8;
    localparam int MAXC = 4096;
    localparam int VW   = ROWS*W + ROWS + 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic              i_valid;
    logic              i_last;
    logic [ROWS*W-1:0] i_act;
    logic [ROWS*W-1:0] o_act;
    logic [ROWS-1:0]   o_row_valid;
    logic              o_ready;
    logic              o_mode;
    logic              o_busy;
    logic              o_done;

    int errors = 0;
    int checks = 0;

    // Model: which cycles accepted a vector, and the window of the current pass.
    int                cyc        = 0;
    int                last_rst   = -1;
    int                pass_start = -1;
    int                pass_last  = -1;
    int                done_cycle = -1;
    bit                acc_v [MAXC];
    logic [ROWS*W-1:0] acc_d [MAXC];
    bit                exp_ready  = 1'b0;
    bit                exp_busy   = 1'b0;
    bit                exp_done   = 1'b0;
    logic [VW-1:0]     exp_vec    = '0;
    logic [VW-1:0]     obs;

    assign obs = {o_act, o_row_valid, o_ready, o_mode, o_busy, o_done};

    always #5 clk = ~clk;

    sa_act_skew #(.ROWS(ROWS), .COLS(COLS), .MUL_DATAWIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_act       (i_act),
        .i_last      (i_last),
        .o_act       (o_act),
        .o_row_valid (o_row_valid),
        .o_mode      (o_mode),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // Row r at cycle c carries whatever was accepted at cycle c-1-r, unless a reset intervened.
    function automatic void compute_expect();
        logic [ROWS*W-1:0] a;
        logic [ROWS-1:0]   v;
        a = '0;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            int s;
            s = cyc - 1 - r;
            if (s >= 0 && s > last_rst && acc_v[s]) begin
                a[r*W +: W] = acc_d[s][r*W +: W];
                v[r]        = 1'b1;
            end
        end
        exp_busy  = pass_start >= 0 && cyc >= pass_start &&
                    (pass_last < 0 || cyc < pass_last + ROWS + COLS);
        exp_ready = pass_start >= 0 && cyc >= pass_start && pass_last < 0;
        exp_done  = (cyc == done_cycle);
        exp_vec   = {a, v, exp_ready, exp_busy, exp_busy, exp_done};
    endfunction

    // Apply the current inputs for one clock, update the model, land #1 after the edge.
    task automatic tick();
        if (rst) begin
            last_rst   = cyc;
            pass_start = -1;
            pass_last  = -1;
            done_cycle = -1;
        end else begin
            if (i_valid && exp_ready) begin
                acc_v[cyc] = 1'b1;
                acc_d[cyc] = i_act;
                if (i_last) begin
                    pass_last  = cyc;
                    done_cycle = cyc + ROWS + COLS;
                end
            end
            if (i_start && !exp_busy) begin
                pass_start = cyc + 1;
                pass_last  = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        compute_expect();
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_act = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_initial cyc=%0d got=%h exp=0", cyc, obs);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL reset_stream cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
            end
            i_valid = 1'b1;
            i_act   = $urandom;
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_midpass cyc=%0d got=%h exp=0", cyc, obs);
        end
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1;
            i_act   = $urandom;
            tick();
            checks++;
            if (o_act !== '0 || o_row_valid !== '0 || o_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_start cyc=%0d got=%h exp=0", cyc, obs);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [W-1:0]      sv [ROWS];
        logic [ROWS*W-1:0] vec;
        sv = '{8'h01, 8'hFE, 8'h03, 8'h80};
        for (int r = 0; r < ROWS; r++) vec[r*W +: W] = sv[r];
        for (int k = 0; k <= 11; k++) begin
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL single_model k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            checks++;
            if (o_mode !== (k >= 1 && k <= 8) || o_done !== (k == 9)) begin
                errors++;
                $display("FAIL single_mode_done k=%0d got mode=%b done=%b", k, o_mode, o_done);
            end
            for (int r = 0; r < ROWS; r++) begin
                if (k == 2 + r) begin
                    checks++;
                    if ({o_row_valid[r], o_act[r*W +: W]} !== {1'b1, sv[r]}) begin
                        errors++;
                        $display("FAIL single_row%0d k=%0d got=%b/%h exp=1/%h", r, k, o_row_valid[r], o_act[r*W +: W], sv[r]);
                    end
                end
            end
            i_start = (k == 0);
            i_valid = (k == 1);
            i_last  = (k == 1);
            i_act   = (k == 1) ? vec : ROWS*W'($urandom);
            tick();
        end
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic test_stream();
        for (int k = 0; k <= 15; k++) begin
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL stream_model k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            checks++;
            if (o_done !== (k == 13)) begin
                errors++;
                $display("FAIL stream_done k=%0d got=%b exp=%b", k, o_done, k == 13);
            end
            for (int r = 0; r < ROWS; r++) begin
                int j;
                j = k - 2 - r;
                if (j >= 0 && j <= 4) begin
                    checks++;
                    if ({o_row_valid[r], o_act[r*W +: W]} !== {1'b1, 8'(10*j + r)}) begin
                        errors++;
                        $display("FAIL stream_row%0d k=%0d got=%b/%h exp=1/%h", r, k, o_row_valid[r], o_act[r*W +: W], 8'(10*j + r));
                    end
                end
            end
            i_start = (k == 0);
            i_valid = (k >= 1 && k <= 5);
            i_last  = (k == 5);
            for (int r = 0; r < ROWS; r++) i_act[r*W +: W] = 8'(10*(k-1) + r);
            tick();
        end
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic test_bubble();
        logic [ROWS*W-1:0] bv [3];
        for (int i = 0; i < 3; i++) bv[i] = ROWS*W'($urandom);
        for (int k = 0; k <= 13; k++) begin
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL bubble_model k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            for (int r = 0; r < ROWS; r++) begin
                logic [W:0] want;
                bit         hit;
                hit = 1'b1;
                if      (k == 2 + r) want = {1'b1, bv[0][r*W +: W]};
                else if (k == 3 + r) want = {1'b1, bv[1][r*W +: W]};
                else if (k == 4 + r) want = '0;
                else if (k == 5 + r) want = {1'b1, bv[2][r*W +: W]};
                else begin
                    want = '0;
                    hit  = 1'b0;
                end
                if (hit) begin
                    checks++;
                    if ({o_row_valid[r], o_act[r*W +: W]} !== want) begin
                        errors++;
                        $display("FAIL bubble_row%0d k=%0d got=%b/%h exp=%h", r, k, o_row_valid[r], o_act[r*W +: W], want);
                    end
                end
            end
            checks++;
            if (o_done !== (k == 12)) begin
                errors++;
                $display("FAIL bubble_done k=%0d got=%b exp=%b", k, o_done, k == 12);
            end
            i_start = (k == 0);
            i_valid = (k == 1 || k == 2 || k == 4);
            i_last  = (k == 4);
            i_act   = (k == 1) ? bv[0] : (k == 2) ? bv[1] : (k == 4) ? bv[2] : ROWS*W'($urandom);
            tick();
        end
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic test_ignored();
        for (int k = 0; k <= 12; k++) begin
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL ignored_model k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            checks++;
            if (o_ready !== (k >= 1 && k <= 3) || o_done !== (k == 11)) begin
                errors++;
                $display("FAIL ignored_ready_done k=%0d got ready=%b done=%b", k, o_ready, o_done);
            end
            i_start = (k == 0 || k == 2 || k == 6);
            i_valid = (k >= 1 && k <= 3) || k == 5 || k == 7;
            i_last  = (k == 3 || k == 7);
            i_act   = ROWS*W'($urandom);
            tick();
        end
        i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic test_restart();
        logic [ROWS*W-1:0] v1;
        logic [ROWS*W-1:0] v2;
        v1 = ROWS*W'($urandom);
        v2 = ROWS*W'($urandom);
        for (int k = 0; k <= 19; k++) begin
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL restart_model k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            checks++;
            if (o_ready !== (k == 1 || k == 10) || o_done !== (k == 9 || k == 18)) begin
                errors++;
                $display("FAIL restart_ready_done k=%0d got ready=%b done=%b", k, o_ready, o_done);
            end
            for (int r = 0; r < ROWS; r++) begin
                if (k == 2 + r || k == 11 + r) begin
                    checks++;
                    if ({o_row_valid[r], o_act[r*W +: W]} !== {1'b1, (k < 11) ? v1[r*W +: W] : v2[r*W +: W]}) begin
                        errors++;
                        $display("FAIL restart_row%0d k=%0d got=%b/%h", r, k, o_row_valid[r], o_act[r*W +: W]);
                    end
                end
            end
            i_start = (k == 0 || k == 9);
            i_valid = (k == 1 || k == 10);
            i_last  = (k == 1 || k == 10);
            i_act   = (k == 1) ? v1 : v2;
            tick();
        end
        i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
            end
            rst     = ($urandom_range(199) == 0);
            i_start = ($urandom_range(7) == 0);
            i_valid = ($urandom_range(1) == 1);
            i_last  = ($urandom_range(5) == 0);
            i_act   = ROWS*W'($urandom);
            tick();
        end
        rst = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        for (int n = 0; n < ROWS + COLS + 2; n++) tick();
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL random_tail cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_bubble();
        test_ignored();
        test_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
